// File: rtl/voter_input_sequencer_pkg.sv
// voter_input_sequencer_pkg: shared widths, FSM state encoding, error codes
// and a candidate range helper for the voter input sequencer slice.
package voter_input_sequencer_pkg;

  localparam int ID_W   = 8;
  localparam int CAND_W = 4;

  // Encodings are visible on seq_state; encoding 2 exists only with VOTE_CONFIRM_EN.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SELECT      = 3'd1,
    ST_CONFIRM     = 3'd2,
    ST_WAIT_RESULT = 3'd3
  } seq_state_t;

  // Sticky error codes reported on seq_error.
  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_NOT_READY = 3'd1,
    ERR_BAD_CAND  = 3'd2,
    ERR_CANCELLED = 3'd3,
    ERR_TIMEOUT   = 3'd4,
    ERR_CONFLICT  = 3'd5
  } seq_err_t;

  // True when a switch-level candidate id names a real candidate.
  function automatic logic cand_in_range(input logic [CAND_W-1:0] cand,
                                         input int num_candidates);
    return (int'(cand) < num_candidates);
  endfunction

endpackage

// File: rtl/voter_input_sequencer_button_debouncer.sv
// button_debouncer: two-flop synchronizer, stability counter and rising-edge
// detector for one raw voter button. A level is accepted only after it has been
// seen unchanged for DEBOUNCE_CYCLES consecutive synchronized samples, so a held
// button yields exactly one single-cycle press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] count;

  // Synchronize the raw level, then adopt it once it has held for the full window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q   <= 2'b00;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      count    <= '0;
    end else begin
      sync_q   <= {sync_q[0], button};
      stable_d <= stable;
      if (sync_q[1] == stable) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable <= sync_q[1];
        count  <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign pressed = stable & ~stable_d;

endmodule

// File: rtl/voter_input_sequencer.sv
// voter_input_sequencer: upstream front end of voting_system_controller.
// Debounces the voter buttons, enforces authenticate -> select -> submit order,
// issues single-cycle authenticate/submit pulses with held voter ID and candidate,
// aborts stalled sessions on timeout and waits for accept/reject.
// Build option: define VOTE_CONFIRM_EN to add the CONFIRM state (two submit presses).
module voter_input_sequencer
  import voter_input_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int NUM_CANDIDATES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   voter_id_raw,
  input  logic [CAND_W-1:0] candidate_raw,
  input  logic              auth_btn,
  input  logic              submit_btn,
  input  logic              cancel_btn,
  input  logic              system_enable,
  input  logic              system_ready,
  input  logic              vote_accepted,
  input  logic              vote_rejected,
  output logic [ID_W-1:0]   voter_id_out,
  output logic [CAND_W-1:0] candidate_out,
  output logic              authenticate_out,
  output logic              submit_out,
  output logic              session_active,
  output logic [2:0]        seq_state,
  output logic [2:0]        seq_error
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic auth_event;
  logic submit_event;
  logic cancel_event;

  seq_state_t        state;
  seq_state_t        state_next;
  logic [2:0]        error_q;
  logic [2:0]        error_next;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   id_next;
  logic [CAND_W-1:0] cand_q;
  logic [CAND_W-1:0] cand_next;
  logic              auth_q;
  logic              auth_next;
  logic              submit_q;
  logic              submit_next;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic              timeout_hit;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auth_db (
    .clk     (clk),
    .reset   (reset),
    .button  (auth_btn),
    .pressed (auth_event)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit_db (
    .clk     (clk),
    .reset   (reset),
    .button  (submit_btn),
    .pressed (submit_event)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel_db (
    .clk     (clk),
    .reset   (reset),
    .button  (cancel_btn),
    .pressed (cancel_event)
  );

  // Register the session state, latched IDs, sticky error, pulses and the state timer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      error_q  <= ERR_NONE;
      id_q     <= '0;
      cand_q   <= '0;
      auth_q   <= 1'b0;
      submit_q <= 1'b0;
      timer    <= '0;
    end else begin
      state    <= state_next;
      error_q  <= error_next;
      id_q     <= id_next;
      cand_q   <= cand_next;
      auth_q   <= auth_next;
      submit_q <= submit_next;
      timer    <= timer_next;
    end
  end

  // Next-state and output decode; event priority is enable > result > cancel > timeout > submit > auth.
  always_comb begin
    state_next  = state;
    error_next  = error_q;
    id_next     = id_q;
    cand_next   = cand_q;
    auth_next   = 1'b0;
    submit_next = 1'b0;
    timeout_hit = (state != ST_IDLE) && (timer == TIMER_LAST);

    if (!system_enable) begin
      // Dropping the enable abandons any session silently; the last error stays visible.
      state_next = ST_IDLE;
      id_next    = '0;
      cand_next  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (auth_event) begin
            if (system_ready) begin
              id_next    = voter_id_raw;
              error_next = ERR_NONE;
              auth_next  = 1'b1;
              state_next = ST_SELECT;
            end else begin
              error_next = ERR_NOT_READY;
            end
          end
        end

        ST_SELECT: begin
          if (cancel_event) begin
            state_next = ST_IDLE;
            error_next = ERR_CANCELLED;
            id_next    = '0;
            cand_next  = '0;
          end else if (timeout_hit) begin
            state_next = ST_IDLE;
            error_next = ERR_TIMEOUT;
            id_next    = '0;
            cand_next  = '0;
          end else if (submit_event) begin
            if (!cand_in_range(candidate_raw, NUM_CANDIDATES)) begin
              error_next = ERR_BAD_CAND;
            end else begin
              cand_next = candidate_raw;
`ifdef VOTE_CONFIRM_EN
              state_next = ST_CONFIRM;
`else
              submit_next = 1'b1;
              state_next  = ST_WAIT_RESULT;
`endif
            end
          end
        end

`ifdef VOTE_CONFIRM_EN
        ST_CONFIRM: begin
          // A moved candidate switch invalidates the pending choice before a submit can use it.
          if (cancel_event) begin
            state_next = ST_IDLE;
            error_next = ERR_CANCELLED;
            id_next    = '0;
            cand_next  = '0;
          end else if (timeout_hit) begin
            state_next = ST_IDLE;
            error_next = ERR_TIMEOUT;
            id_next    = '0;
            cand_next  = '0;
          end else if (candidate_raw != cand_q) begin
            state_next = ST_SELECT;
          end else if (submit_event) begin
            submit_next = 1'b1;
            state_next  = ST_WAIT_RESULT;
          end
        end
`endif

        ST_WAIT_RESULT: begin
          if (vote_accepted || vote_rejected) begin
            state_next = ST_IDLE;
            id_next    = '0;
            cand_next  = '0;
            if (vote_accepted && vote_rejected) begin
              error_next = ERR_CONFLICT;
            end
          end else if (timeout_hit) begin
            state_next = ST_IDLE;
            error_next = ERR_TIMEOUT;
            id_next    = '0;
            cand_next  = '0;
          end
        end

        default: begin
          state_next = ST_IDLE;
          id_next    = '0;
          cand_next  = '0;
        end
      endcase
    end

    if ((state_next != state) || (state == ST_IDLE)) begin
      timer_next = '0;
    end else begin
      timer_next = timer + TIMER_W'(1);
    end
  end

  assign voter_id_out     = id_q;
  assign candidate_out    = cand_q;
  assign authenticate_out = auth_q;
  assign submit_out       = submit_q;
  assign session_active   = (state != ST_IDLE);
  assign seq_state        = state;
  assign seq_error        = error_q;

endmodule

// File: tb/tb_voter_input_sequencer.sv
// tb_voter_input_sequencer: scoreboard bench for voter_input_sequencer.
// Stimulus issues whole button presses and controller results while a small
// session model predicts state, error and the pulses the DUT must present.
`timescale 1ns/1ps
module tb_voter_input_sequencer;

  localparam int DEB   = 16;
  localparam int TMO   = 1024;
  localparam int NCAND = 4;
  localparam int HOLD  = DEB + 8;
`ifdef VOTE_CONFIRM_EN
  localparam bit CONFIRM_MODE = 1'b1;
`else
  localparam bit CONFIRM_MODE = 1'b0;
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_CONFIRM = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] E_NOT_READY = 3'd1;
  localparam logic [2:0] E_BAD_CAND  = 3'd2;
  localparam logic [2:0] E_CANCEL    = 3'd3;
  localparam logic [2:0] E_TIMEOUT   = 3'd4;
  localparam logic [2:0] E_CONFLICT  = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] voter_id_raw = 8'h00;
  logic [3:0] candidate_raw = 4'h0;
  logic       auth_btn = 1'b0;
  logic       submit_btn = 1'b0;
  logic       cancel_btn = 1'b0;
  logic       system_enable = 1'b1;
  logic       system_ready = 1'b1;
  logic       vote_accepted = 1'b0;
  logic       vote_rejected = 1'b0;
  logic [7:0] voter_id_out;
  logic [3:0] candidate_out;
  logic       authenticate_out;
  logic       submit_out;
  logic       session_active;
  logic [2:0] seq_state;
  logic [2:0] seq_error;

  always #5 clk = ~clk;

  voter_input_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO),
    .NUM_CANDIDATES (NCAND)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .voter_id_raw    (voter_id_raw),
    .candidate_raw   (candidate_raw),
    .auth_btn        (auth_btn),
    .submit_btn      (submit_btn),
    .cancel_btn      (cancel_btn),
    .system_enable   (system_enable),
    .system_ready    (system_ready),
    .vote_accepted   (vote_accepted),
    .vote_rejected   (vote_rejected),
    .voter_id_out    (voter_id_out),
    .candidate_out   (candidate_out),
    .authenticate_out(authenticate_out),
    .submit_out      (submit_out),
    .session_active  (session_active),
    .seq_state       (seq_state),
    .seq_error       (seq_error)
  );

  typedef struct {
    bit         is_submit;
    logic [7:0] id;
    logic [3:0] cand;
  } pulse_t;

  typedef enum int {
    OP_AUTH, OP_SUBMIT, OP_CANCEL, OP_ACCEPT, OP_REJECT, OP_CONFLICT,
    OP_TIMEOUT, OP_DISABLE, OP_RESET, OP_CAND_CHANGE
  } op_t;

  pulse_t     exp_q[$];
  int         check_count = 0;
  int         pass_count = 0;
  logic [2:0] model_state = S_IDLE;
  logic [2:0] model_err = 3'd0;
  logic [7:0] model_id = 8'h00;
  logic [3:0] model_cand = 4'h0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Scoreboard monitor: each presented pulse must match the oldest expected pulse.
  always @(negedge clk) begin
    pulse_t p;
    if (authenticate_out || submit_out) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", 32'({authenticate_out, submit_out}), 32'd0);
      end else begin
        p = exp_q.pop_front();
        checkOutput(p.is_submit ? "submit_pulse" : "auth_pulse",
          32'({authenticate_out, submit_out, voter_id_out,
               p.is_submit ? candidate_out : 4'h0}),
          32'({~p.is_submit, p.is_submit, p.id, p.is_submit ? p.cand : 4'h0}));
      end
    end
  end

  task automatic pushPulse(input bit is_submit, input logic [7:0] id, input logic [3:0] cand);
    pulse_t p;
    p.is_submit = is_submit;
    p.id        = id;
    p.cand      = cand;
    exp_q.push_back(p);
  endtask

  task automatic pressButton(input int which);
    @(negedge clk);
    case (which)
      0: auth_btn = 1'b1;
      1: submit_btn = 1'b1;
      default: cancel_btn = 1'b1;
    endcase
    repeat (HOLD) @(negedge clk);
    auth_btn   = 1'b0;
    submit_btn = 1'b0;
    cancel_btn = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_state"}, 32'(seq_state), 32'(model_state));
    checkOutput({tag, "_error"}, 32'(seq_error), 32'(model_err));
    checkOutput({tag, "_active"}, 32'(session_active), 32'(model_state != S_IDLE));
    checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic applyStimulus(input op_t op);
    bit was_wait;
    was_wait = (model_state == S_WAIT);
    case (op)
      OP_AUTH: begin
        if (model_state == S_IDLE) begin
          if (system_ready) begin
            pushPulse(1'b0, voter_id_raw, 4'h0);
            model_state = S_SELECT;
            model_err   = 3'd0;
            model_id    = voter_id_raw;
          end else begin
            model_err = E_NOT_READY;
          end
        end
        pressButton(0);
      end
      OP_SUBMIT: begin
        if (model_state == S_SELECT) begin
          if (int'(candidate_raw) >= NCAND) begin
            model_err = E_BAD_CAND;
          end else begin
            model_cand = candidate_raw;
            if (CONFIRM_MODE) begin
              model_state = S_CONFIRM;
            end else begin
              pushPulse(1'b1, model_id, model_cand);
              model_state = S_WAIT;
            end
          end
        end else if (model_state == S_CONFIRM) begin
          pushPulse(1'b1, model_id, model_cand);
          model_state = S_WAIT;
        end
        pressButton(1);
      end
      OP_CANCEL: begin
        if (model_state == S_SELECT || model_state == S_CONFIRM) begin
          model_state = S_IDLE;
          model_err   = E_CANCEL;
        end
        pressButton(2);
      end
      OP_ACCEPT, OP_REJECT, OP_CONFLICT: begin
        if (model_state == S_WAIT) begin
          model_state = S_IDLE;
          if (op == OP_CONFLICT) model_err = E_CONFLICT;
        end
        @(negedge clk);
        vote_accepted = (op != OP_REJECT);
        vote_rejected = (op != OP_ACCEPT);
        @(negedge clk);
        vote_accepted = 1'b0;
        vote_rejected = 1'b0;
        repeat (2) @(negedge clk);
        if (was_wait) begin
          checkOutput("result_id_cleared", 32'(voter_id_out), 32'd0);
          checkOutput("result_cand_cleared", 32'(candidate_out), 32'd0);
        end
      end
      OP_TIMEOUT: begin
        repeat (TMO + 64) @(negedge clk);
        if (model_state != S_IDLE) begin
          model_state = S_IDLE;
          model_err   = E_TIMEOUT;
        end
      end
      OP_DISABLE: begin
        @(negedge clk);
        system_enable = 1'b0;
        @(negedge clk);
        system_enable = 1'b1;
        repeat (2) @(negedge clk);
        model_state = S_IDLE;
      end
      OP_RESET: begin
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_state = S_IDLE;
        model_err   = 3'd0;
        checkOutput("reset_id_cleared", 32'(voter_id_out), 32'd0);
      end
      OP_CAND_CHANGE: begin
        @(negedge clk);
        candidate_raw = model_cand ^ 4'h1;
        repeat (3) @(negedge clk);
        if (model_state == S_CONFIRM) model_state = S_SELECT;
      end
      default: ;
    endcase
    checkState(op.name());
  endtask

  task automatic runSession();
    int r;
    if ($urandom_range(0, 7) == 0) begin
      system_ready = 1'b0;
      voter_id_raw = 8'($urandom);
      applyStimulus(OP_AUTH);
      system_ready = 1'b1;
    end
    if ($urandom_range(0, 7) == 0) applyStimulus(OP_CANCEL);
    voter_id_raw = 8'($urandom);
    applyStimulus(OP_AUTH);
    repeat ($urandom_range(0, 2)) begin
      candidate_raw = 4'($urandom_range(NCAND, 15));
      applyStimulus(OP_SUBMIT);
    end
    r = int'($urandom_range(0, 9));
    if (r == 0) begin applyStimulus(OP_CANCEL); return; end
    if (r == 1) begin applyStimulus(OP_TIMEOUT); return; end
    if (r == 2) begin applyStimulus(OP_DISABLE); return; end
    if (r == 3) begin applyStimulus(OP_RESET); return; end
    candidate_raw = 4'($urandom_range(0, NCAND - 1));
    applyStimulus(OP_SUBMIT);
`ifdef VOTE_CONFIRM_EN
    if ($urandom_range(0, 3) == 0) begin
      applyStimulus(OP_CAND_CHANGE);
      applyStimulus(OP_SUBMIT);
    end
    if ($urandom_range(0, 4) == 0) begin
      applyStimulus(OP_CANCEL);
      return;
    end
    applyStimulus(OP_SUBMIT);
`endif
    if ($urandom_range(0, 4) == 0) applyStimulus(OP_CANCEL);
    r = int'($urandom_range(0, 9));
    if (r < 5) applyStimulus(OP_ACCEPT);
    else if (r < 8) applyStimulus(OP_REJECT);
    else if (r == 8) applyStimulus(OP_CONFLICT);
    else applyStimulus(OP_TIMEOUT);
  endtask

  initial begin
    $display("[TB] voter_input_sequencer bench, confirm mode %0d", CONFIRM_MODE);

    // Reset held with every button pressed: all outputs must read zero.
    auth_btn   = 1'b1;
    submit_btn = 1'b1;
    cancel_btn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
      32'({voter_id_out, candidate_out, authenticate_out, submit_out,
           session_active, seq_state, seq_error}), 32'd0);
    reset      = 1'b1;
    auth_btn   = 1'b0;
    submit_btn = 1'b0;
    cancel_btn = 1'b0;
    repeat (40) @(negedge clk);
    checkState("after_reset");

    // Bouncing auth button never settles long enough to count.
    for (int i = 0; i < 5; i++) begin
      auth_btn = 1'b1;
      @(negedge clk);
      auth_btn = 1'b0;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    checkState("bounce");

    // Directed vote: id 2A, candidate 2, accepted.
    voter_id_raw = 8'h2A;
    applyStimulus(OP_AUTH);
    checkOutput("held_voter_id", 32'(voter_id_out), 32'h2A);
    candidate_raw = 4'd2;
    applyStimulus(OP_SUBMIT);
`ifdef VOTE_CONFIRM_EN
    checkOutput("confirm_wait_state", 32'(seq_state), 32'(S_CONFIRM));
    applyStimulus(OP_SUBMIT);
`endif
    checkOutput("held_candidate", 32'(candidate_out), 32'd2);
    applyStimulus(OP_ACCEPT);

    // Out-of-range candidate, then cancel.
    voter_id_raw = 8'h51;
    applyStimulus(OP_AUTH);
    candidate_raw = 4'd7;
    applyStimulus(OP_SUBMIT);
    checkOutput("bad_cand_error", 32'(seq_error), 32'(E_BAD_CAND));
    applyStimulus(OP_CANCEL);

    // Stalled session times out.
    voter_id_raw = 8'hC3;
    applyStimulus(OP_AUTH);
    applyStimulus(OP_TIMEOUT);
    checkOutput("timeout_error", 32'(seq_error), 32'(E_TIMEOUT));

    // Authenticate while controller is busy.
    system_ready = 1'b0;
    applyStimulus(OP_AUTH);
    system_ready = 1'b1;

    for (int s = 0; s < 30; s++) runSession();

    checkOutput("leftover_pulses", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
